// File: rtl/tpu_array_ctrl_pkg.sv
// Shared constants for the systolic array sequencer: data width, FSM encoding and
// default geometry.
package tpu_array_ctrl_pkg;

  localparam int DATA_SIZE   = 8;
  localparam int ARRAY_N_DEF = 5;
  localparam int MAX_M_DEF   = 64;
  localparam int IDXW_DEF    = 7;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD_W  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

endpackage

// File: rtl/tpu_array_ctrl_skew_window.sv
// One skewed stream window: valid while offset <= t < offset+m, index = t-offset.
// Used once per input row and once per output column.
module ctrl_skew_window #(
  parameter int IDXW = 7
) (
  input  logic            en,
  input  logic [IDXW:0]   t,
  input  logic [IDXW:0]   offset,
  input  logic [IDXW:0]   m,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  logic [IDXW:0] rel;

  // The extra bit keeps t-offset from wrapping before the lower bound is checked.
  assign rel   = t - offset;
  assign valid = en && (t >= offset) && (rel < m);
  assign idx   = valid ? (t[IDXW-1:0] - offset[IDXW-1:0]) : '0;

endmodule

// File: rtl/tpu_array_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, skewed input streaming and
// result write strobes. Optional weight reuse (keep_w) under CTRL_WEIGHT_REUSE_EN.
module tpu_array_ctrl
  import tpu_array_ctrl_pkg::*;
#(
  parameter int ARRAY_N = ARRAY_N_DEF,
  parameter int MAX_M   = MAX_M_DEF,
  parameter int IDXW    = IDXW_DEF,
  localparam int AW     = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDXW-1:0]         m_len,
  input  logic                    abort,
`ifdef CTRL_WEIGHT_REUSE_EN
  input  logic                    keep_w,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd,
  output logic [AW-1:0]           w_addr,
  output logic [ARRAY_N-1:0]      weight_en,
  output logic [ARRAY_N-1:0]      in_rd,
  output logic [ARRAY_N*IDXW-1:0] in_idx,
  output logic [ARRAY_N-1:0]      row_valid,
  output logic                    go,
  output logic [ARRAY_N-1:0]      out_wr,
  output logic [ARRAY_N*IDXW-1:0] out_idx
);

  localparam logic [IDXW:0]   T_LOAD_LAST = (IDXW+1)'(ARRAY_N);
  localparam logic [IDXW:0]   T_SKEW      = (IDXW+1)'(2*ARRAY_N - 1);
  localparam logic [IDXW-1:0] M_CAP       = IDXW'(MAX_M);

  logic [1:0]      state, state_next;
  logic [IDXW:0]   t, t_next;
  logic [IDXW-1:0] m_reg, m_next, m_req;
  logic [IDXW:0]   m_ext;

  logic                    w_rd_next;
  logic [AW-1:0]           w_addr_next;
  logic [ARRAY_N-1:0]      weight_en_next;
  logic [ARRAY_N-1:0]      in_rd_next;
  logic [ARRAY_N*IDXW-1:0] in_idx_next;
  logic [ARRAY_N-1:0]      out_wr_next;
  logic [ARRAY_N*IDXW-1:0] out_idx_next;

  // Out-of-range vector counts saturate at the array's maximum job length.
  assign m_req  = (m_len > M_CAP) ? M_CAP : m_len;
  assign m_next = (state == IDLE && start) ? m_req : m_reg;
  assign m_ext  = {1'b0, m_next};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (m_len == '0)
            state_next = DONE;
`ifdef CTRL_WEIGHT_REUSE_EN
          else if (keep_w)
            state_next = COMPUTE;
`endif
          else
            state_next = LOAD_W;
        end
      end
      LOAD_W: begin
        if (abort)
          state_next = IDLE;
        else if (t == T_LOAD_LAST)
          state_next = COMPUTE;
      end
      COMPUTE: begin
        if (abort)
          state_next = IDLE;
        else if (t == ({1'b0, m_reg} + T_SKEW))
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // t restarts on every state entry and idles at zero.
  assign t_next = (state_next == state && state_next != IDLE) ? t + 1'b1 : '0;

  // Outputs are decoded from the next state/count so the registered strobes line up
  // with the state they belong to.
  assign w_rd_next   = (state_next == LOAD_W) && (t_next < T_LOAD_LAST);
  assign w_addr_next = w_rd_next ? t_next[AW-1:0] : '0;

  for (genvar gi = 0; gi < ARRAY_N; gi++) begin : g_lane
    assign weight_en_next[gi] = (state_next == LOAD_W) && (t_next == (IDXW+1)'(gi + 1));

    ctrl_skew_window #(.IDXW(IDXW)) u_row_win (
      .en     (state_next == COMPUTE),
      .t      (t_next),
      .offset ((IDXW+1)'(gi)),
      .m      (m_ext),
      .valid  (in_rd_next[gi]),
      .idx    (in_idx_next[gi*IDXW +: IDXW])
    );

    // Column c drains after the N-deep row pipeline plus its own horizontal skew.
    ctrl_skew_window #(.IDXW(IDXW)) u_col_win (
      .en     (state_next == COMPUTE),
      .t      (t_next),
      .offset ((IDXW+1)'(gi + ARRAY_N + 1)),
      .m      (m_ext),
      .valid  (out_wr_next[gi]),
      .idx    (out_idx_next[gi*IDXW +: IDXW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      m_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      weight_en <= '0;
      in_rd     <= '0;
      in_idx    <= '0;
      row_valid <= '0;
      go        <= 1'b0;
      out_wr    <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_next;
      t         <= t_next;
      m_reg     <= m_next;
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      w_rd      <= w_rd_next;
      w_addr    <= w_addr_next;
      weight_en <= weight_en_next;
      in_rd     <= in_rd_next;
      in_idx    <= in_idx_next;
      row_valid <= (state_next == COMPUTE) ? in_rd : '0;
      go        <= (state_next == COMPUTE);
      out_wr    <= out_wr_next;
      out_idx   <= out_idx_next;
    end
  end

endmodule

// File: tb/tb_tpu_array_ctrl.sv
// Bench for tpu_array_ctrl: drives jobs from a vector table, runs a behavioural PE array
// off the controller strobes and scoreboards results against a matrix-product model.
module tb_tpu_array_ctrl;

  localparam int N    = 5;
  localparam int IDXW = 7;
  localparam int MAXM = 64;
  localparam int AW   = $clog2(N);

  logic                 clk, rst, start, abort;
  logic [IDXW-1:0]      m_len;
`ifdef CTRL_WEIGHT_REUSE_EN
  logic                 keep_w;
`endif
  logic                 busy, done, w_rd, go;
  logic [AW-1:0]        w_addr;
  logic [N-1:0]         weight_en, in_rd, row_valid, out_wr;
  logic [N*IDXW-1:0]    in_idx, out_idx;

  tpu_array_ctrl #(.ARRAY_N(N), .MAX_M(MAXM), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m_len     (m_len),
    .abort     (abort),
`ifdef CTRL_WEIGHT_REUSE_EN
    .keep_w    (keep_w),
`endif
    .busy      (busy),
    .done      (done),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .weight_en (weight_en),
    .in_rd     (in_rd),
    .in_idx    (in_idx),
    .row_valid (row_valid),
    .go        (go),
    .out_wr    (out_wr),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Buffers and behavioural PE array
  int wbuf [N][N];
  int xbuf [MAXM][N];
  int ymat [MAXM][N];
  int wdata [N];
  int rdata [N];
  int wreg [N][N];
  int act  [N][N];
  int ps   [N][N];

  function automatic int ain(input int r, input int c);
    if (c == 0) return row_valid[r] ? rdata[r] : 0;
    return act[r][c-1];
  endfunction

  always @(posedge clk) begin
    if (w_rd)
      for (int c = 0; c < N; c++) wdata[c] <= wbuf[w_addr][c];
    for (int r = 0; r < N; r++) begin
      if (weight_en[r])
        for (int c = 0; c < N; c++) wreg[r][c] <= wdata[c];
      if (in_rd[r])
        rdata[r] <= xbuf[in_idx[r*IDXW +: IDXW]][r];
    end
    if (go)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          act[r][c] <= ain(r, c);
          ps[r][c]  <= ((r == 0) ? 0 : ps[r-1][c]) + wreg[r][c] * ain(r, c);
        end
  end

  // Scoreboard: expected (column, index, value) in emission order
  typedef struct {
    int c;
    int idx;
    int val;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (out_wr[c]) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "sb_unexpected_out_wr", c, -1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk(e.c == c, "sb_column", c, e.c);
          chk(e.idx == int'(out_idx[c*IDXW +: IDXW]), "sb_out_idx",
              int'(out_idx[c*IDXW +: IDXW]), e.idx);
          chk(e.val == ps[N-1][c], "sb_result", ps[N-1][c], e.val);
        end
      end
    end
  end

  typedef struct {
    int m;
    int pat;
    int base;
    int abort_cyc;
    int restart_cyc;
    int exp_lat;
  } vec_t;

  task automatic run_job(input int m, input int pat, input int base, input int abort_cyc,
                         input int restart_cyc, input int exp_lat, input bit keep,
                         input bit spec_trace);
    int lat, dones, limit;
    int wrd_n, we_n, inrd_n, ow_n, go_n, busy_n;
    if (!keep)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          wbuf[r][c] = (pat == 0) ? int'(r == c) : (r + 2 * c + 1);
    for (int k = 0; k < MAXM; k++)
      for (int r = 0; r < N; r++) xbuf[k][r] = base + k * N + r + 1;
    for (int k = 0; k < MAXM; k++)
      for (int c = 0; c < N; c++) begin
        ymat[k][c] = 0;
        for (int r = 0; r < N; r++) ymat[k][c] += xbuf[k][r] * wbuf[r][c];
      end
    if (abort_cyc == 0 && m > 0)
      for (int t = 0; t < m + 2 * N; t++)
        for (int c = 0; c < N; c++)
          if (t >= c + N + 1 && t <= c + N + m)
            sb_q.push_back('{c, t - c - N - 1, ymat[t - c - N - 1][c]});

    @(posedge clk);
    #1;
    start = 1'b1;
    m_len = IDXW'(m);
`ifdef CTRL_WEIGHT_REUSE_EN
    keep_w = keep;
`endif
    lat = -1; dones = 0;
    wrd_n = 0; we_n = 0; inrd_n = 0; ow_n = 0; go_n = 0; busy_n = 0;
    limit = (exp_lat >= 0) ? exp_lat + 10 : 60;
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      wrd_n  += int'(w_rd);
      we_n   += $countones(weight_en);
      inrd_n += $countones(in_rd);
      ow_n   += $countones(out_wr);
      go_n   += int'(go);
      busy_n += int'(busy);
      if (spec_trace && cyc <= 20) begin
        int we_exp;
        we_exp = (cyc >= 2 && cyc <= 6) ? (1 << (cyc - 2)) : 0;
        chk(int'(weight_en) == we_exp, "trace_weight_en", int'(weight_en), we_exp);
        chk(in_rd[4] == (cyc >= 11 && cyc <= 13), "trace_in_rd4", int'(in_rd[4]),
            int'(cyc >= 11 && cyc <= 13));
        if (cyc >= 11 && cyc <= 13)
          chk(int'(in_idx[4*IDXW +: IDXW]) == cyc - 11, "trace_in_idx4",
              int'(in_idx[4*IDXW +: IDXW]), cyc - 11);
        chk(out_wr[0] == (cyc >= 13 && cyc <= 15), "trace_out_wr0", int'(out_wr[0]),
            int'(cyc >= 13 && cyc <= 15));
        chk(out_wr[4] == (cyc >= 17 && cyc <= 19), "trace_out_wr4", int'(out_wr[4]),
            int'(cyc >= 17 && cyc <= 19));
      end
      if (cyc == 1) start = 1'b0;
      if (restart_cyc > 0 && cyc == restart_cyc) begin
        start = 1'b1;
        m_len = '0;
      end
      if (restart_cyc > 0 && cyc == restart_cyc + 1) start = 1'b0;
      if (abort_cyc > 0 && cyc == abort_cyc) abort = 1'b1;
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        abort = 1'b0;
        chk(!busy, "abort_busy", int'(busy), 0);
        chk(!go, "abort_go", int'(go), 0);
        chk({w_rd, weight_en, in_rd, row_valid, out_wr} == '0, "abort_strobes",
            int'({w_rd, weight_en, in_rd, row_valid, out_wr}), 0);
      end
      if (lat >= 0 && cyc >= lat + 6) break;
    end
`ifdef CTRL_WEIGHT_REUSE_EN
    keep_w = 1'b0;
`endif
    if (exp_lat < 0) begin
      chk(dones == 0, "abort_no_done", dones, 0);
    end else begin
      chk(lat == exp_lat, "latency", lat, exp_lat);
      chk(dones == 1, "done_count", dones, 1);
      chk(wrd_n == ((m > 0 && !keep) ? N : 0), "w_rd_cycles", wrd_n, (m > 0 && !keep) ? N : 0);
      chk(we_n == ((m > 0 && !keep) ? N : 0), "weight_en_bits", we_n, (m > 0 && !keep) ? N : 0);
      chk(inrd_n == N * m, "in_rd_bits", inrd_n, N * m);
      chk(ow_n == N * m, "out_wr_bits", ow_n, N * m);
      chk(go_n == ((m > 0) ? m + 2 * N : 0), "go_cycles", go_n, (m > 0) ? m + 2 * N : 0);
      chk(busy_n == exp_lat, "busy_cycles", busy_n, exp_lat);
    end
    chk(sb_q.size() == 0, "sb_drained", sb_q.size(), 0);
    sb_q.delete();
    $display("job m=%0d pat=%0d abort=%0d restart=%0d keep=%0d latency=%0d",
             m, pat, abort_cyc, restart_cyc, int'(keep), lat);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3,  0, 0,  0,  0, 20};
    vecs[1] = '{0,  0, 0,  0,  0, 1};
    vecs[2] = '{1,  1, 20, 0,  0, 18};
    vecs[3] = '{5,  1, 40, 0,  0, 22};
    vecs[4] = '{3,  0, 0,  11, 0, -1};
    vecs[5] = '{3,  0, 60, 0,  0, 20};
    vecs[6] = '{2,  1, 80, 0,  5, 19};
    vecs[7] = '{64, 1, 0,  0,  0, 81};

    rst = 1'b0; start = 1'b0; abort = 1'b0; m_len = '0;
`ifdef CTRL_WEIGHT_REUSE_EN
    keep_w = 1'b0;
`endif
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(!busy && !done && !go, "reset_ctrl", int'({busy, done, go}), 0);
    chk({w_rd, w_addr, weight_en, in_rd, row_valid, out_wr} == '0, "reset_strobes",
        int'({w_rd, w_addr, weight_en, in_rd, row_valid, out_wr}), 0);
    chk(in_idx == '0 && out_idx == '0, "reset_idx", int'(in_idx != '0 || out_idx != '0), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_job(vecs[i].m, vecs[i].pat, vecs[i].base, vecs[i].abort_cyc,
              vecs[i].restart_cyc, vecs[i].exp_lat, 1'b0, i == 0);

    // Reset asserted mid weight-load
    begin
      int dn;
      @(posedge clk);
      #1;
      start = 1'b1;
      m_len = IDXW'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk(w_rd && busy, "pre_rst_load", int'({w_rd, busy}), 3);
      #1 rst = 1'b1;
      #1;
      chk(!busy, "rst_busy", int'(busy), 0);
      chk(!w_rd && w_addr == '0, "rst_w_rd", int'({w_rd, w_addr}), 0);
      chk(weight_en == '0, "rst_weight_en", int'(weight_en), 0);
      chk(!done && !go, "rst_done_go", int'({done, go}), 0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        dn += int'(done);
      end
      chk(dn == 0, "rst_no_done", dn, 0);
      $display("reset during LOAD_W: extra done pulses=%0d", dn);
    end

    run_job(3, 1, 100, 0, 7, 20, 1'b0, 1'b0);

`ifdef CTRL_WEIGHT_REUSE_EN
    run_job(3, 1, 7, 0, 0, 14, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
